div_issue_ctrl: RTL and testbench

//  Sequential issue/retire stage wrapped around the combinational divider datapath.

---
 rtl/div_issue_ctrl_if.sv | 46 ++++
 rtl/div_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// Bundle of the decode-side request channel, the divider datapath connection
// and the writeback result channel of div_issue_ctrl.
//   in_*        : op request from decode (valid/ready)
//   div_*       : magnitude operands to / unsigned results from the divider
//   out_*       : result to writeback (valid/ready)
// Modports:
//   slave  : the issue controller itself
//   master : the surrounding decode/divider/writeback environment
interface div_issue_ctrl_if #(
    parameter int N     = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [N-1:0]     in_rs1;
    logic [N-1:0]     in_rs2;
    logic [TAG_W-1:0] in_rd;
    logic [N-1:0]     div_dividend;
    logic [N-1:0]     div_divisor;
    logic [N-1:0]     div_quotient;
    logic [N-1:0]     div_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_rd;
    logic             out_dz;

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd,
        input  div_quotient, div_remainder,
        input  out_ready,
        output in_ready,
        output div_dividend, div_divisor,
        output out_valid, out_data, out_rd, out_dz
    );

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd,
        output div_quotient, div_remainder,
        output out_ready,
        input  in_ready,
        input  div_dividend, div_divisor,
        input  out_valid, out_data, out_rd, out_dz
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/retire stage around a combinational unsigned divider.
// Takes DIVU/DIV/REMU/REM (in_op 00/01/10/11) from decode, presents operand
// magnitudes to the divider, holds them DIV_LAT cycles, then sign-corrects
// the sampled quotient/remainder and hands one result to writeback.
// Divide-by-zero and the signed MIN/-1 overflow are answered directly.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : div_issue_ctrl_if.slave (request, divider and result channels)
module div_issue_ctrl #(
    parameter int N       = 16,
    parameter int DIV_LAT = 2,
    parameter int TAG_W   = 4
) (
    input logic              clk,
    input logic              rst,
    div_issue_ctrl_if.slave  bus
);

    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_rem;
    logic             neg_q;
    logic             neg_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [N-1:0]     out_data_r;
    logic [TAG_W-1:0] out_rd_r;
    logic             out_dz_r;
    logic [N-1:0]     dividend_r;
    logic [N-1:0]     divisor_r;

    logic             in_signed;
    logic             in_zero;
    logic             in_ovf;

    // MIN maps to 1<<(N-1), which is exact when read as unsigned.
    function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] v,
                                               input logic is_signed);
        logic signed [N-1:0] n;
        n = -v;
        return (is_signed && v[N-1]) ? $unsigned(n) : $unsigned(v);
    endfunction

    function automatic logic [N-1:0] apply_sign(input logic [N-1:0] v,
                                                input logic neg);
        logic signed [N-1:0] s;
        s = -$signed(v);
        return neg ? $unsigned(s) : v;
    endfunction

    always_comb begin
        in_signed = bus.in_op[0];
        in_zero   = (bus.in_rs2 == '0);
        in_ovf    = in_signed && (bus.in_rs1 == MOST_NEG) && (bus.in_rs2 == '1);
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = out_data_r;
    assign bus.out_rd       = out_rd_r;
    assign bus.out_dz       = out_dz_r;
    assign bus.div_dividend = dividend_r;
    assign bus.div_divisor  = divisor_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_rem      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_rd_r    <= '0;
            out_dz_r    <= 1'b0;
            dividend_r  <= '0;
            divisor_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        op_rem     <= bus.in_op[1];
                        neg_q      <= in_signed & (bus.in_rs1[N-1] ^ bus.in_rs2[N-1]);
                        neg_r      <= in_signed & bus.in_rs1[N-1];
                        out_rd_r   <= bus.in_rd;
                        dividend_r <= magnitude(bus.in_rs1, in_signed);
                        divisor_r  <= magnitude(bus.in_rs2, in_signed);
                        in_ready_r <= 1'b0;
                        if (in_zero) begin
                            // Quotient all ones, remainder is the raw dividend.
                            out_data_r  <= bus.in_op[1] ? bus.in_rs1 : '1;
                            out_dz_r    <= 1'b1;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else if (in_ovf) begin
                            // MIN / -1 wraps back to MIN with zero remainder.
                            out_data_r  <= bus.in_op[1] ? '0 : bus.in_rs1;
                            out_dz_r    <= 1'b0;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            out_dz_r <= 1'b0;
                            cnt      <= CNT_W'(DIV_LAT - 1);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        out_data_r  <= op_rem ? apply_sign(bus.div_remainder, neg_r)
                                              : apply_sign(bus.div_quotient, neg_q);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural unsigned divider.
module tb_div_issue_ctrl;

    localparam int N       = 16;
    localparam int DIV_LAT = 2;
    localparam int TAG_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic corrupt = 1'b0;   // forces junk on the divider outputs

    int n_checks = 0;
    int n_errors = 0;

    div_issue_ctrl_if #(.N(N), .TAG_W(TAG_W)) bus ();

    div_issue_ctrl #(.N(N), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.div_quotient  = corrupt ? 16'hA5A5 :
                               (bus.div_divisor == '0) ? '1 : bus.div_dividend / bus.div_divisor;
    assign bus.div_remainder = corrupt ? 16'h5A5A :
                               (bus.div_divisor == '0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int budget;
        budget = 20;
        while (!bus.in_ready && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Issue one op with out_ready=1 and check latency, result and the
    // single-cycle out_valid pulse.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] rd, input logic [15:0] exp,
                          input logic exp_dz, input int lat);
        wait_ready(tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_rd    = rd;
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        for (int k = 1; k < lat; k++) begin
            check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
            tick();
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
        check({tag, "_rd"}, 32'(bus.out_rd), 32'(rd));
        check({tag, "_dz"}, 32'(bus.out_dz), 32'(exp_dz));
        tick();
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b1;

        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_rd", 32'(bus.out_rd), 32'd0);
        check("rst_out_dz", 32'(bus.out_dz), 32'd0);
        check("rst_dividend", 32'(bus.div_dividend), 32'd0);
        check("rst_divisor", 32'(bus.div_divisor), 32'd0);

        // Unsigned
        run_op("divu_100_7", 2'b00, 16'd100, 16'd7, 4'd1, 16'd14, 1'b0, 3);
        run_op("remu_100_7", 2'b10, 16'd100, 16'd7, 4'd2, 16'd2, 1'b0, 3);
        run_op("divu_ff9c_7", 2'b00, 16'hFF9C, 16'd7, 4'd3, 16'h2484, 1'b0, 3);
        check("divu_dividend", 32'(bus.div_dividend), 32'hFF9C);

        // Signed
        run_op("div_m100_7", 2'b01, 16'hFF9C, 16'd7, 4'd4, 16'hFFF2, 1'b0, 3);
        check("div_mag_dividend", 32'(bus.div_dividend), 32'd100);
        check("div_mag_divisor", 32'(bus.div_divisor), 32'd7);
        run_op("rem_m100_7", 2'b11, 16'hFF9C, 16'd7, 4'd5, 16'hFFFE, 1'b0, 3);
        run_op("rem_100_m7", 2'b11, 16'd100, 16'hFFF9, 4'd6, 16'd2, 1'b0, 3);
        check("rem_mag_divisor", 32'(bus.div_divisor), 32'd7);
        run_op("div_100_m7", 2'b01, 16'd100, 16'hFFF9, 4'd7, 16'hFFF2, 1'b0, 3);
        run_op("div_min_2", 2'b01, 16'h8000, 16'd2, 4'd8, 16'hC000, 1'b0, 3);
        check("min_mag_dividend", 32'(bus.div_dividend), 32'h8000);

        // Local special cases; the divider output is junk and must be ignored
        corrupt = 1'b1;
        run_op("divu_5_0", 2'b00, 16'd5, 16'd0, 4'd9, 16'hFFFF, 1'b1, 1);
        run_op("rem_fffb_0", 2'b11, 16'hFFFB, 16'd0, 4'd10, 16'hFFFB, 1'b1, 1);
        run_op("div_min_m1", 2'b01, 16'h8000, 16'hFFFF, 4'd11, 16'h8000, 1'b0, 1);
        run_op("rem_min_m1", 2'b11, 16'h8000, 16'hFFFF, 4'd12, 16'h0000, 1'b0, 1);
        corrupt = 1'b0;

        // Backpressure in DONE with a request waiting
        bus.out_ready = 1'b0;
        wait_ready("bp");
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b00;
        bus.in_rs1   = 16'd100;
        bus.in_rs2   = 16'd7;
        bus.in_rd    = 4'd5;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b00;
        bus.in_rs1   = 16'd9;
        bus.in_rs2   = 16'd0;
        bus.in_rd    = 4'd9;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", 32'(bus.out_data), 32'd14);
            check("bp_rd", 32'(bus.out_rd), 32'd5);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        check("bp_hold_data", 32'(bus.out_data), 32'd14);
        bus.out_ready = 1'b1;
        tick();
        check("bp_hs_drop", 32'(bus.out_valid), 32'd0);
        check("bp_hs_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_next_valid", 32'(bus.out_valid), 32'd1);
        check("bp_next_data", 32'(bus.out_data), 32'hFFFF);
        check("bp_next_rd", 32'(bus.out_rd), 32'd9);
        check("bp_next_dz", 32'(bus.out_dz), 32'd1);
        tick();
        check("bp_next_drop", 32'(bus.out_valid), 32'd0);

        // Reset while waiting on the divider
        wait_ready("rst_mid");
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b01;
        bus.in_rs1   = 16'hFF9C;
        bus.in_rs2   = 16'd7;
        bus.in_rd    = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mid_dividend", 32'(bus.div_dividend), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_mid_no_result", 32'(bus.out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
